// File: rtl/crc_engine_param.sv
// crc_engine_param: parametrised multi-bit CRC generator/checker on a valid/ready
// stream framed by sof/eof. Each completed frame yields a registered CRC, a residue
// check and a saturating beat count, announced by a one-cycle crc_valid pulse.
module crc_engine_param #(
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h8005,
  parameter logic [CRC_W-1:0] INIT    = 16'h0000,
  parameter logic [CRC_W-1:0] XOROUT  = 16'h0000,
  parameter int unsigned      DATA_W  = 8,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE = 16'h0000,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              crc_valid,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_ok,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              err_nosof
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CRC_W-1:0] crc_reg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CRC_W-1:0] seed;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_rev;
  logic [CRC_W-1:0] crc_final;
  logic             accept;
  logic             load_beat;
  logic             finish;
  logic             nosof_beat;
  logic             fb;
  logic             bit_in;

  // A beat is taken on the handshake; it feeds the CRC only when it starts a frame
  // or continues an open one. Non-sof beats outside a frame are dropped and flagged.
  assign accept     = in_valid & in_ready;
  assign load_beat  = accept & (in_sof | (state == BUSY));
  assign finish     = load_beat & in_eof;
  assign nosof_beat = accept & ~in_sof & (state == IDLE);

  // sof always restarts from INIT, even in the middle of an open frame.
  assign seed = in_sof ? INIT : crc_reg;

  // Unrolled per-bit LFSR update over the whole beat in processing order.
  always_comb begin
    crc_next = seed;
    fb       = 1'b0;
    bit_in   = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      bit_in   = REFIN ? in_data[i] : in_data[int'(DATA_W) - 1 - i];
      fb       = crc_next[CRC_W-1] ^ bit_in;
      crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  // Bit-reversed view of the updated register for reflected output.
  genvar gi;
  generate
    for (gi = 0; gi < int'(CRC_W); gi++) begin : g_rev
      assign crc_rev[gi] = crc_next[int'(CRC_W) - 1 - gi];
    end
  endgenerate

  assign crc_final = (REFOUT ? crc_rev : crc_next) ^ XOROUT;

  // Beat counter restarts at 1 on sof and sticks at all-ones.
  assign cnt_next = in_sof ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DONE lasts exactly one cycle and is the per-frame bubble.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && in_sof) state_next = in_eof ? DONE : BUSY;
      BUSY: if (accept && in_eof) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only, so in_ready never depends on in_valid.
  always_comb begin
    in_ready  = 1'b1;
    crc_valid = 1'b0;
    if (state == DONE) begin
      in_ready  = 1'b0;
      crc_valid = 1'b1;
    end
  end

  // Working register, counter, held frame results and the sticky no-sof flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg   <= INIT;
      cnt       <= '0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      beat_cnt  <= '0;
      err_nosof <= 1'b0;
    end else begin
      if (load_beat) begin
        crc_reg <= crc_next;
        cnt     <= cnt_next;
      end
      if (finish) begin
        crc_out  <= crc_final;
        crc_ok   <= (crc_next == RESIDUE);
        beat_cnt <= cnt_next;
      end
      if (nosof_beat) begin
        err_nosof <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc_engine_param.sv
// tb_crc_engine_param: three instances (plain CRC-16/8005 bytewise, reflected ARC with a
// 3-bit counter, and a 1-bit-wide variant) checked every cycle against a behavioural
// model that computes CRCs by polynomial long division over the frame's bit stream.
module tb_crc_engine_param;

  logic        clk;
  logic        rst;
  logic        vin   [3];
  logic [31:0] din   [3];
  logic        sof_i [3];
  logic        eof_i [3];

  logic        rdy0, rdy1, rdy2;
  logic        cv0, cv1, cv2;
  logic [15:0] co0, co1, co2;
  logic        ok0, ok1, ok2;
  logic [15:0] bc0, bc2;
  logic [2:0]  bc1;
  logic        err0, err1, err2;

  logic        rdy_a [3];
  logic        cv_a  [3];
  logic [15:0] co_a  [3];
  logic        ok_a  [3];
  logic [15:0] bc_a  [3];
  logic        err_a [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  localparam int DW_C    [3] = '{8, 8, 1};
  localparam int REFIN_C [3] = '{0, 1, 0};
  localparam int REFOUT_C[3] = '{0, 1, 0};
  localparam int CW_C    [3] = '{16, 3, 16};

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  crc_engine_param u0 (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(rdy0), .in_data(din[0][7:0]),
    .in_sof(sof_i[0]), .in_eof(eof_i[0]), .crc_valid(cv0), .crc_out(co0), .crc_ok(ok0),
    .beat_cnt(bc0), .err_nosof(err0)
  );

  crc_engine_param #(.REFIN(1'b1), .REFOUT(1'b1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(rdy1), .in_data(din[1][7:0]),
    .in_sof(sof_i[1]), .in_eof(eof_i[1]), .crc_valid(cv1), .crc_out(co1), .crc_ok(ok1),
    .beat_cnt(bc1), .err_nosof(err1)
  );

  crc_engine_param #(.DATA_W(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(rdy2), .in_data(din[2][0:0]),
    .in_sof(sof_i[2]), .in_eof(eof_i[2]), .crc_valid(cv2), .crc_out(co2), .crc_ok(ok2),
    .beat_cnt(bc2), .err_nosof(err2)
  );

  assign rdy_a[0] = rdy0;  assign rdy_a[1] = rdy1;  assign rdy_a[2] = rdy2;
  assign cv_a[0]  = cv0;   assign cv_a[1]  = cv1;   assign cv_a[2]  = cv2;
  assign co_a[0]  = co0;   assign co_a[1]  = co1;   assign co_a[2]  = co2;
  assign ok_a[0]  = ok0;   assign ok_a[1]  = ok1;   assign ok_a[2]  = ok2;
  assign bc_a[0]  = bc0;   assign bc_a[1]  = {13'd0, bc1}; assign bc_a[2] = bc2;
  assign err_a[0] = err0;  assign err_a[1] = err1;  assign err_a[2] = err2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Remainder of M(x)*x^16 divided by x^16+x^15+x^2+1 (INIT is zero for all instances).
  function automatic logic [15:0] poly_mod(input bit q[$]);
    bit          w[$];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h18005;
    w = q;
    repeat (16) w.push_back(1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (w[i]) begin
        for (int j = 0; j < 17; j++) w[i+j] = w[i+j] ^ g[16-j];
      end
    end
    for (int j = 0; j < 16; j++) r[15-j] = w[q.size()+j];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) r[j] = v[15-j];
    return r;
  endfunction

  bit          m_busy [3];
  bit          m_done [3];
  bit          m_err  [3];
  bit          m_ok   [3];
  logic [15:0] m_out  [3];
  logic [15:0] m_cnto [3];
  int          m_cnt  [3];
  bit          m_bits [3][$];

  // Frame-level model: tracks open frame bits, bubble after each result, sticky error.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_ok[i] = 0;
        m_out[i] = 16'h0; m_cnto[i] = 16'h0; m_cnt[i] = 0;
        m_bits[i].delete();
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_done[i]) begin
          m_done[i] = 0;
        end else if (vin[i]) begin
          if (sof_i[i] || m_busy[i]) begin
            logic [15:0] raw;
            if (sof_i[i]) begin
              m_bits[i].delete();
              m_cnt[i] = 1;
            end else if (m_cnt[i] < (1 << CW_C[i]) - 1) begin
              m_cnt[i] = m_cnt[i] + 1;
            end
            for (int k = 0; k < DW_C[i]; k++)
              m_bits[i].push_back(din[i][(REFIN_C[i] != 0) ? k : DW_C[i] - 1 - k]);
            m_busy[i] = 1;
            if (eof_i[i]) begin
              raw       = poly_mod(m_bits[i]);
              m_busy[i] = 0;
              m_done[i] = 1;
              m_ok[i]   = (raw == 16'h0000);
              m_out[i]  = (REFOUT_C[i] != 0) ? rev16(raw) : raw;
              m_cnto[i] = 16'(m_cnt[i]);
            end
          end else begin
            m_err[i] = 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("in_ready",  i, 32'(rdy_a[i]), 32'(!m_done[i]));
        chk("crc_valid", i, 32'(cv_a[i]),  32'(m_done[i]));
        chk("crc_out",   i, 32'(co_a[i]),  32'(m_out[i]));
        chk("crc_ok",    i, 32'(ok_a[i]),  32'(m_ok[i]));
        chk("beat_cnt",  i, 32'(bc_a[i]),  32'(m_cnto[i]));
        chk("err_nosof", i, 32'(err_a[i]), 32'(m_err[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present one beat to the masked instances and hold it until it is accepted.
  task automatic beat(input bit [2:0] mask, input logic [31:0] d, input bit s, input bit e);
    int guard;
    bit acc;
    guard = 0;
    acc   = 0;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        vin[i] = 1'b1; din[i] = d; sof_i[i] = s; eof_i[i] = e;
      end
    end
    while (!acc) begin
      acc = 1'b1;
      for (int i = 0; i < 3; i++) if (mask[i] && !rdy_a[i]) acc = 1'b0;
      @(negedge clk);
      guard++;
      if (!acc && guard > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout mask %0b: got no in_ready expected accept", mask);
        acc = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        vin[i] = 1'b0; sof_i[i] = 1'b0; eof_i[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit q[$];
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 0; din[i] = 0; sof_i[i] = 0; eof_i[i] = 0;
    end

    // Pin the model against known check values.
    for (int k = 0; k < 72; k++) q.push_back(msg[k/8][7-(k%8)]);
    chk("model_fee8", 0, 32'(poly_mod(q)), 32'h0000FEE8);
    q.delete();
    for (int k = 0; k < 72; k++) q.push_back(msg[k/8][k%8]);
    chk("model_bb3d", 1, 32'(rev16(poly_mod(q))), 32'h0000BB3D);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_ready",  0, 32'(rdy0), 32'd1);
    chk("reset_valid",  0, 32'(cv0),  32'd0);
    chk("reset_crc",    0, 32'(co0),  32'd0);
    chk("reset_cnt",    0, 32'(bc0),  32'd0);

    // "123456789" bytewise, plain and ARC in parallel.
    for (int k = 0; k < 9; k++) beat(3'b011, 32'(msg[k]), k == 0, k == 8);
    chk("std_valid", 0, 32'(cv0),  32'd1);
    chk("std_ready", 0, 32'(rdy0), 32'd0);
    chk("std_crc",   0, 32'(co0),  32'hFEE8);
    chk("std_cnt",   0, 32'(bc0),  32'd9);
    chk("arc_crc",   1, 32'(co1),  32'hBB3D);
    chk("arc_cnt_sat", 1, 32'(bc1), 32'd7);
    repeat (2) @(negedge clk);
    chk("std_hold",  0, 32'(co0),  32'hFEE8);

    // Residue check: data plus appended CRC, then with one flipped bit.
    for (int k = 0; k < 11; k++)
      beat(3'b001, (k < 9) ? 32'(msg[k]) : ((k == 9) ? 32'hFE : 32'hE8), k == 0, k == 10);
    chk("residue_ok", 0, 32'(ok0), 32'd1);
    for (int k = 0; k < 11; k++)
      beat(3'b001, (k < 9) ? 32'(msg[k] ^ ((k == 3) ? 8'h01 : 8'h00))
                           : ((k == 9) ? 32'hFE : 32'hE8), k == 0, k == 10);
    chk("residue_bad", 0, 32'(ok0), 32'd0);

    // Serial instance, MSB-first.
    for (int k = 0; k < 72; k++) beat(3'b100, 32'(msg[k/8][7-(k%8)]), k == 0, k == 71);
    chk("bit_crc", 2, 32'(co2), 32'hFEE8);
    chk("bit_cnt", 2, 32'(bc2), 32'd72);

    // Beat without sof in IDLE.
    beat(3'b001, 32'hAA, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("nosof_err",   0, 32'(err0), 32'd1);
    chk("nosof_valid", 0, 32'(cv0),  32'd0);

    // Reset in the middle of a frame.
    beat(3'b011, 32'h31, 1'b1, 1'b0);
    beat(3'b011, 32'h32, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_err",   0, 32'(err0), 32'd0);
    chk("midrst_crc",   0, 32'(co0),  32'd0);
    chk("midrst_ok",    0, 32'(ok0),  32'd0);
    chk("midrst_cnt",   0, 32'(bc0),  32'd0);
    chk("midrst_ready", 0, 32'(rdy0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Random frames with gaps, mid-frame sof restarts and stray beats.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) beat(3'b011, $urandom, 1'b0, 1'b0);
      for (int k = 0; k < len; k++) begin
        bit s;
        s = (k == 0) || ($urandom_range(0, 7) == 0);
        beat(3'b011, $urandom, s, k == len - 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    for (int f = 0; f < 10; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        beat(3'b100, $urandom, (k == 0) || ($urandom_range(0, 9) == 0), k == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
